// File: rtl/rtp_mon_pkg.sv
// rtp_mon_pkg: shared types and helpers for the RTP result monitor.
// Run-state enum, channel-index width, popcount and saturating add.
package rtp_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } mon_state_e;

   localparam int MAX_CH    = 8;
   localparam int MAX_CNT_W = 64;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [3:0] popcount8(
      input logic [MAX_CH-1:0] v
   );
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < MAX_CH; i++)
         c = c + {3'b000, v[i]};
      return c;
   endfunction

   // a + b clamped to max; callers pass max = all-ones of their width.
   function automatic logic [MAX_CNT_W-1:0] sat_add(
      input logic [MAX_CNT_W-1:0] a,
      input logic [MAX_CNT_W-1:0] b,
      input logic [MAX_CNT_W-1:0] max
   );
      logic [MAX_CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, max})
         return max;
      return s[MAX_CNT_W-1:0];
   endfunction

endpackage

// File: rtl/rtp_mon_fifo.sv
// rtp_mon_fifo: synchronous show-ahead FIFO with flush.
// Ports: i_clk/i_rst_n, i_flush, i_push/i_wdata, i_pop, o_rdata (head), o_full, o_empty.
module rtp_mon_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wp;
   logic [AW:0]      r_rp;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB tells full from empty when the indices match.
   assign o_empty   = (r_wp == r_rp);
   assign o_full    = (r_wp[AW] != r_rp[AW]) &&
                      (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_do_push = i_push & ~o_full & ~i_flush;
   assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
   assign o_rdata   = r_mem[r_rp[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_do_push)
         r_mem[r_wp[AW-1:0]] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp <= '0;
         r_rp <= '0;
      end else if (i_flush) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_do_push)
            r_wp <= r_wp + (AW+1)'(1);
         if (w_do_pop)
            r_rp <= r_rp + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/rtp_result_monitor.sv
// rtp_result_monitor: round-robin result collector and run monitor for NUM_CH RTP cores.
// Ports: i_start, per-channel valid/hitT/id/finish/fdiv in, o_ch_ready; head out_* with i_out_ready; run status and counters.
module rtp_result_monitor
   import rtp_mon_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int ID_W        = 32,
   parameter int HITT_W      = 32,
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 64,
   parameter int TIMEOUT_CYC = 1048576,
   localparam int CH_W       = ch_width(NUM_CH)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [NUM_CH-1:0]        i_ch_valid,
   input  logic [NUM_CH*HITT_W-1:0] i_ch_hitT,
   input  logic [NUM_CH*ID_W-1:0]   i_ch_ray_id,
   input  logic [NUM_CH-1:0]        i_ch_finish,
   output logic [NUM_CH-1:0]        o_ch_ready,
   input  logic [NUM_CH-1:0]        i_fdiv_pulse,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [HITT_W-1:0]        o_out_hitT,
   output logic [ID_W-1:0]          o_out_ray_id,
   output logic [CH_W-1:0]          o_out_ch,
   output logic                     o_run_finish,
   output logic                     o_run_timeout,
   output logic [CNT_W-1:0]         o_total_cycle,
   output logic [CNT_W-1:0]         o_counter_fdiv,
   output logic [CNT_W-1:0]         o_rays_done
);

   localparam int FW    = HITT_W + ID_W + CH_W;
   localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'({CNT_W{1'b1}});

   mon_state_e        r_state;
   logic [CH_W-1:0]   r_prio;
   logic [NUM_CH-1:0] r_fin;
   logic [WD_W-1:0]   r_wd;
   logic [CNT_W-1:0]  r_tc;
   logic [CNT_W-1:0]  r_fd;
   logic [CNT_W-1:0]  r_rd;
   logic              r_finish;
   logic              r_timeout;

   logic                w_active;
   logic                w_restart;
   logic [2*NUM_CH-1:0] w_dbl;
   logic [NUM_CH-1:0]   w_rot;
   logic                w_found;
   logic [CH_W:0]       w_sum;
   logic [CH_W-1:0]     w_gidx;
   logic [CH_W:0]       w_nxt;
   logic [NUM_CH-1:0]   w_gnt;
   logic [HITT_W-1:0]   w_sel_hitT;
   logic [ID_W-1:0]     w_sel_id;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_all_fin;
   logic [FW-1:0]       w_rdata;
   logic [3:0]          w_pc;

   assign w_active  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_restart = i_start & ~w_active;

   // Rotate valids so bit 0 is the highest-priority channel.
   assign w_dbl = {i_ch_valid, i_ch_valid};
   assign w_rot = NUM_CH'(w_dbl >> r_prio);

   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_sum   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, r_prio} + (CH_W+1)'(k);
            if (w_sum >= (CH_W+1)'(NUM_CH))
               w_sum = w_sum - (CH_W+1)'(NUM_CH);
            w_gidx = w_sum[CH_W-1:0];
         end
      end
   end

   always_comb begin
      w_gnt      = '0;
      w_sel_hitT = '0;
      w_sel_id   = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (w_found && (w_gidx == CH_W'(j))) begin
            w_gnt[j]   = 1'b1;
            w_sel_hitT = i_ch_hitT[j*HITT_W +: HITT_W];
            w_sel_id   = i_ch_ray_id[j*ID_W +: ID_W];
         end
      end
   end

   always_comb begin
      w_nxt = {1'b0, w_gidx} + (CH_W+1)'(1);
      if (w_nxt == (CH_W+1)'(NUM_CH))
         w_nxt = '0;
   end

   assign o_ch_ready = (w_active && !w_full) ? w_gnt : '0;
   assign w_push     = |(i_ch_valid & o_ch_ready);
   assign o_out_valid = ~w_empty;
   assign w_pop      = o_out_valid & i_out_ready;
   assign w_all_fin  = &(r_fin | i_ch_finish);
   assign w_pc       = popcount8(MAX_CH'(i_fdiv_pulse));

   rtp_mon_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (w_restart),
      .i_push  (w_push),
      .i_wdata ({w_gidx, w_sel_id, w_sel_hitT}),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Head fields read as zero when empty so stale entries never show.
   assign o_out_hitT   = o_out_valid ? w_rdata[HITT_W-1:0] : '0;
   assign o_out_ray_id = o_out_valid ? w_rdata[HITT_W +: ID_W] : '0;
   assign o_out_ch     = o_out_valid ? w_rdata[FW-1 -: CH_W] : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_prio    <= '0;
         r_fin     <= '0;
         r_wd      <= '0;
         r_tc      <= '0;
         r_fd      <= '0;
         r_rd      <= '0;
         r_finish  <= 1'b0;
         r_timeout <= 1'b0;
      end else if (w_restart) begin
         r_state   <= ST_RUN;
         r_prio    <= '0;
         r_fin     <= '0;
         r_wd      <= '0;
         r_tc      <= '0;
         r_fd      <= '0;
         r_rd      <= '0;
         r_finish  <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (w_active) begin
            r_tc  <= CNT_W'(sat_add(MAX_CNT_W'(r_tc),
                                    MAX_CNT_W'(1), CNT_MAX));
            r_fd  <= CNT_W'(sat_add(MAX_CNT_W'(r_fd),
                                    MAX_CNT_W'(w_pc), CNT_MAX));
            r_fin <= r_fin | i_ch_finish;
         end
         if (w_pop)
            r_rd <= CNT_W'(sat_add(MAX_CNT_W'(r_rd),
                                   MAX_CNT_W'(1), CNT_MAX));
         if (w_push)
            r_prio <= w_nxt[CH_W-1:0];
         if (w_push || w_pop)
            r_wd <= '0;
         case (r_state)
            ST_RUN: begin
               if (w_all_fin)
                  r_state <= ST_DRAIN;
               else if (!(w_push || w_pop)) begin
                  if (r_wd == WD_LAST) begin
                     r_state   <= ST_TIMEOUT;
                     r_timeout <= 1'b1;
                  end else
                     r_wd <= r_wd + WD_W'(1);
               end
            end
            ST_DRAIN: begin
               if (w_empty && !w_push) begin
                  r_state  <= ST_DONE;
                  r_finish <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_run_finish   = r_finish;
   assign o_run_timeout  = r_timeout;
   assign o_total_cycle  = r_tc;
   assign o_counter_fdiv = r_fd;
   assign o_rays_done    = r_rd;

endmodule

// File: tb/tb_rtp_result_monitor.sv
// tb_rtp_result_monitor: directed plus random checks of rtp_result_monitor
// against a queue-based reference model.
module tb_rtp_result_monitor;

   localparam int NCH = 2;
   localparam int IDW = 32;
   localparam int HW  = 32;
   localparam int DEP = 8;
   localparam int CW  = 64;
   localparam int TO  = 16;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_DRN  = 2;
   localparam int S_DONE = 3;
   localparam int S_TO   = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [NCH-1:0]    ch_valid = '0;
   logic [NCH*HW-1:0] ch_hitT = '0;
   logic [NCH*IDW-1:0] ch_ray_id = '0;
   logic [NCH-1:0]    ch_finish = '0;
   logic [NCH-1:0]    fdiv = '0;
   logic              out_ready = 1'b0;

   logic [NCH-1:0]    ch_ready;
   logic              out_valid;
   logic [HW-1:0]     out_hitT;
   logic [IDW-1:0]    out_ray_id;
   logic [0:0]        out_ch;
   logic              run_finish;
   logic              run_timeout;
   logic [CW-1:0]     total_cycle;
   logic [CW-1:0]     counter_fdiv;
   logic [CW-1:0]     rays_done;

   rtp_result_monitor #(
      .NUM_CH (NCH), .ID_W (IDW), .HITT_W (HW),
      .FIFO_DEPTH (DEP), .CNT_W (CW), .TIMEOUT_CYC (TO)
   ) dut (
      .i_clk (clk), .i_rst_n (rst_n), .i_start (start),
      .i_ch_valid (ch_valid), .i_ch_hitT (ch_hitT),
      .i_ch_ray_id (ch_ray_id), .i_ch_finish (ch_finish),
      .o_ch_ready (ch_ready), .i_fdiv_pulse (fdiv),
      .o_out_valid (out_valid), .i_out_ready (out_ready),
      .o_out_hitT (out_hitT), .o_out_ray_id (out_ray_id),
      .o_out_ch (out_ch), .o_run_finish (run_finish),
      .o_run_timeout (run_timeout), .o_total_cycle (total_cycle),
      .o_counter_fdiv (counter_fdiv), .o_rays_done (rays_done)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [HW-1:0]  h;
      logic [IDW-1:0] id;
      int             ch;
   } ent_t;

   ent_t        q[$];
   int          m_st = S_IDLE;
   int          m_prio = 0;
   bit [NCH-1:0] m_fin = '0;
   int          m_idle = 0;
   longint unsigned m_tc = 0;
   longint unsigned m_fd = 0;
   longint unsigned m_rd = 0;

   function automatic bit m_act();
      return (m_st == S_RUN) || (m_st == S_DRN);
   endfunction

   function automatic int m_grant();
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = (m_prio + k) % NCH;
         if (ch_valid[c]) return c;
      end
      return -1;
   endfunction

   function automatic int m_ready_ch();
      int g;
      g = m_grant();
      if (m_act() && g >= 0 && q.size() < DEP) return g;
      return -1;
   endfunction

   task automatic m_clear();
      q.delete();
      m_prio = 0; m_fin = '0; m_idle = 0;
      m_tc = 0; m_fd = 0; m_rd = 0;
   endtask

   task automatic m_step();
      int  g;
      bit  act, pop, acc;
      ent_t e;
      act = m_act();
      if (start && !act) begin
         m_clear();
         m_st = S_RUN;
         return;
      end
      g   = m_ready_ch();
      acc = (g >= 0);
      pop = (q.size() > 0) && out_ready;
      if (act) begin
         m_tc++;
         m_fd += $countones(fdiv);
         m_fin = m_fin | ch_finish;
      end
      if (pop) m_rd++;
      if (m_st == S_RUN) begin
         if (&m_fin) m_st = S_DRN;
         else if (acc || pop) m_idle = 0;
         else if (m_idle == TO - 1) m_st = S_TO;
         else m_idle++;
      end else if (m_st == S_DRN) begin
         if (q.size() == 0 && !acc) m_st = S_DONE;
      end
      if (pop) void'(q.pop_front());
      if (acc) begin
         e.h  = ch_hitT[g*HW +: HW];
         e.id = ch_ray_id[g*IDW +: IDW];
         e.ch = g;
         q.push_back(e);
         m_prio = (g + 1) % NCH;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_clear();
         m_st = S_IDLE;
      end else
         m_step();
   end

   // ---------------- per-cycle compare ----------------
   int          log_ch[$];
   logic [31:0] log_id[$];

   always @(negedge clk) begin
      int g;
      logic [NCH-1:0] er;
      g  = m_ready_ch();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("ch_ready", 64'(ch_ready), 64'(er));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("out_hitT", 64'(out_hitT), (q.size() > 0) ? 64'(q[0].h) : 64'd0);
      chk("out_ray_id", 64'(out_ray_id),
          (q.size() > 0) ? 64'(q[0].id) : 64'd0);
      chk("out_ch", 64'(out_ch), (q.size() > 0) ? 64'(q[0].ch) : 64'd0);
      chk("run_finish", 64'(run_finish), 64'(m_st == S_DONE));
      chk("run_timeout", 64'(run_timeout), 64'(m_st == S_TO));
      chk("total_cycle", total_cycle, m_tc);
      chk("counter_fdiv", counter_fdiv, m_fd);
      chk("rays_done", rays_done, m_rd);
      if (rst_n && out_valid && out_ready) begin
         log_ch.push_back(int'(out_ch));
         log_id.push_back(out_ray_id);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(ch_ready), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_tc", total_cycle, 64'd0);
      chk("rst_finish", 64'(run_finish), 64'd0);
      rst_n = 1'b1;
      tick();

      // Alternating grants with both channels valid.
      pulse_start();
      log_ch.delete(); log_id.delete();
      ch_valid  = 2'b11;
      ch_ray_id = {32'h0000_00B1, 32'h0000_00A0};
      ch_hitT   = {32'h3F80_0000, 32'h4000_0000};
      out_ready = 1'b1;
      #1 chk("alt_first_ready", 64'(ch_ready), 64'd1);
      repeat (4) tick();
      ch_valid = 2'b00;
      repeat (2) tick();
      chk("alt_rays", rays_done, 64'd4);
      chk("alt_npop", 64'(log_ch.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         if (i < log_ch.size())
            chk("alt_ch", 64'(log_ch[i]), 64'(i % 2));

      // Three queued, then all finish: DRAIN then DONE.
      out_ready = 1'b0;
      ch_valid  = 2'b01;
      for (int k = 0; k < 3; k++) begin
         ch_ray_id[31:0] = 32'h100 + 32'(k);
         tick();
      end
      ch_valid  = 2'b00;
      ch_finish = 2'b11;
      tick();
      ch_finish = 2'b00;
      chk("drain_finish", 64'(run_finish), 64'd0);
      out_ready = 1'b1;
      repeat (3) tick();
      chk("drain_not_done", 64'(run_finish), 64'd0);
      tick();
      chk("done_finish", 64'(run_finish), 64'd1);
      chk("done_rays", rays_done, 64'd7);
      chk("done_tc", total_cycle, 64'd14);
      repeat (2) tick();
      chk("done_tc_frozen", total_cycle, 64'd14);

      // Full boundary: nine offered, eight taken.
      pulse_start();
      out_ready = 1'b0;
      ch_valid  = 2'b01;
      for (int k = 0; k < 9; k++) begin
         ch_ray_id[31:0] = 32'h200 + 32'(k);
         #1;
         if (k == 7) chk("full_last_ready", 64'(ch_ready), 64'd1);
         if (k == 8) chk("full_ready_low", 64'(ch_ready), 64'd0);
         tick();
      end
      ch_valid = 2'b00;
      log_ch.delete(); log_id.delete();
      out_ready = 1'b1;
      repeat (9) tick();
      chk("full_npop", 64'(log_id.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         if (i < log_id.size())
            chk("full_order", 64'(log_id[i]), 64'(32'h200 + 32'(i)));
      chk("full_empty", 64'(out_valid), 64'd0);
      repeat (20) tick();
      chk("idle_timeout", 64'(run_timeout), 64'd1);

      // FDIV counting and watchdog timeout; start in RUN ignored.
      out_ready = 1'b0;
      pulse_start();
      chk("restart_tc", total_cycle, 64'd0);
      chk("restart_fd", counter_fdiv, 64'd0);
      chk("restart_rd", rays_done, 64'd0);
      chk("restart_to", 64'(run_timeout), 64'd0);
      fdiv = 2'b11;
      repeat (5) tick();
      fdiv = 2'b00;
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("to_not_yet", 64'(run_timeout), 64'd0);
      tick();
      chk("to_hit", 64'(run_timeout), 64'd1);
      chk("to_tc", total_cycle, 64'd16);
      chk("to_fd", counter_fdiv, 64'd10);
      fdiv = 2'b11;
      repeat (3) tick();
      fdiv = 2'b00;
      chk("to_fd_frozen", counter_fdiv, 64'd10);

      // Async reset with four entries queued.
      pulse_start();
      ch_valid = 2'b11;
      repeat (4) tick();
      ch_valid = 2'b00;
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      ch_valid = 2'b11;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_ready", 64'(ch_ready), 64'd0);
      chk("arst_tc", total_cycle, 64'd0);
      chk("arst_hitT", 64'(out_hitT), 64'd0);
      tick();
      rst_n = 1'b1;
      #1 chk("idle_ready", 64'(ch_ready), 64'd0);
      ch_valid = 2'b00;
      tick();

      // Randomised traffic in phases of varying density.
      for (int c = 0; c < 4000; c++) begin
         int mode;
         mode = (c / 400) % 4;
         ch_hitT   = {$urandom, $urandom};
         ch_ray_id = {$urandom, $urandom};
         case (mode)
            0: ch_valid = NCH'($urandom_range(0, 3));
            1: ch_valid = ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b00;
            2: ch_valid = 2'b00;
            default: ch_valid = NCH'($urandom_range(0, 3));
         endcase
         out_ready = (mode == 3) ? ($urandom_range(0, 7) == 0)
                                 : ($urandom_range(0, 3) != 0);
         ch_finish[0] = ($urandom_range(0, 119) == 0);
         ch_finish[1] = ($urandom_range(0, 119) == 0);
         fdiv  = NCH'($urandom_range(0, 3));
         start = (c == 0) || ($urandom_range(0, 39) == 0);
         tick();
      end
      start = 1'b0; ch_valid = '0; ch_finish = '0; fdiv = '0;
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/rtp_result_monitor.md
# rtp_result_monitor

Parametrised result collector and performance monitor for multi-core ray-tracing runs. It accepts hit results (hitT, ray id) from NUM_CH ray-traversal cores through round-robin arbitration into a FIFO, counts run cycles, FDIV events and retired rays, and declares run completion or watchdog timeout. It sits between the RTP cores and the host/bench sink, and generalises the single-core finish/hitT/fdiv-counter outputs to N channels with flow control.

## Interface
- NUM_CH, 2: number of RTP core channels (1..8)
- ID_W, 32: ray id width
- HITT_W, 32: hitT width (raw IEEE-754 bits, not interpreted)
- FIFO_DEPTH, 8: result FIFO entries, power of 2, ≥2
- CNT_W, 64: width of cycle/fdiv/ray counters
- TIMEOUT_CYC, 1048576: idle cycles in RUN before timeout
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear counters, flush FIFO, begin run
- ch_valid  in  NUM_CH  per-channel result valid
- ch_hitT  in  NUM_CH*HITT_W  packed hitT, channel i at [i*HITT_W +: HITT_W]
- ch_ray_id  in  NUM_CH*ID_W  packed ray id
- ch_finish  in  NUM_CH  per-channel core-done level
- ch_ready  out  NUM_CH  one-hot (or zero) accept
- fdiv_pulse  in  NUM_CH  one FDIV event per set bit per cycle
- out_valid  out  1  FIFO head valid
- out_ready  in  1  sink accepts head
- out_hitT  out  HITT_W  head hitT
- out_ray_id  out  ID_W  head ray id
- out_ch  out  $clog2(NUM_CH) (min 1)  source channel of head
- run_finish  out  1  level, high in DONE
- run_timeout  out  1  level, high in TIMEOUT
- total_cycle  out  CNT_W  cycles spent in RUN+DRAIN
- counter_fdiv  out  CNT_W  FDIV events in RUN+DRAIN
- rays_done  out  CNT_W  results popped by sink

## Operation
- States: IDLE, RUN, DRAIN, DONE, TIMEOUT. Reset → IDLE.
- start in IDLE/DONE/TIMEOUT → RUN; clears all counters, finish latches, watchdog, FIFO pointers, RR pointer. start in RUN/DRAIN ignored.
- Arbiter (RUN and DRAIN only): priority begins at channel (last_grant+1) mod NUM_CH; grant = first valid channel. ch_ready = grant & ~fifo_full; zero in IDLE/DONE/TIMEOUT. Accept = ch_valid & ch_ready; last_grant updates only on accept.
- FIFO: show-ahead; push on accept, pop on out_valid & out_ready; simultaneous push/pop legal (count unchanged). No push when full (ch_ready low), no pop when empty.
- Finish latch: sticky per channel, set by ch_finish in RUN/DRAIN. RUN → DRAIN when all latches set (including current-cycle ch_finish). DRAIN → DONE when FIFO empty and no accept that cycle.
- Watchdog: counts in RUN; cleared on any accept or pop; reaching TIMEOUT_CYC-1 → TIMEOUT. Not active in DRAIN.
- Counters saturate at all-ones. counter_fdiv adds popcount(fdiv_pulse). rays_done increments per pop in any state with non-empty FIFO.
- In TIMEOUT/DONE, sink may still drain FIFO contents.

## Timing
- Reset values: all outputs 0; ch_ready 0; state IDLE.
- Accept at edge t → out_valid high after edge t (visible cycle t+1) when FIFO was empty.
- total_cycle increments on every edge spent in RUN or DRAIN, including the edge leaving it.
- run_finish/run_timeout rise the cycle after the transition, hold until next start or reset.
- Async reset mid-run clears everything immediately; no result is retained.

## Structure
- Package rtp_mon_pkg: state enum, popcount and saturating-add functions, localparam CH_W = max(1,$clog2(NUM_CH)).
- Sub-module rtp_mon_fifo: parametrised synchronous show-ahead FIFO (width HITT_W+ID_W+CH_W, depth FIFO_DEPTH) with full/empty/flush.

## Test plan
- NUM_CH=2, both ch_valid held with distinct ids, out_ready=1 → grants alternate 0,1,0,1; out_ch sequence 0,1,0,1; rays_done=4 after 4 pops.
- out_ready=0, ch0 streams 9 results, depth 8 → 8 accepted, ch_ready[0] low on 9th; raising out_ready drains in order, FIFO full/empty boundaries clean.
- Both ch_finish asserted with 3 entries queued → DRAIN; after 3 pops → DONE, run_finish=1, total_cycle frozen.
- TIMEOUT_CYC=16, no valids, no finish → run_timeout=1 after 16 RUN cycles; start → RUN, counters 0.
- fdiv_pulse=2'b11 for 5 cycles in RUN → counter_fdiv=10; in IDLE → unchanged.
- Assert reset low while FIFO holds 4 entries → out_valid, counters, ch_ready 0 immediately; state IDLE.
